// File: rtl/p2_anim_ctrl.sv
// Player-2 animation sequencer and sprite pixel fetcher.
// Optional: define P2_ANIM_MIRROR_EN to add the facing input (horizontal mirror).
module p2_anim_ctrl #(
  parameter int FRAME_DIV = 6,
  parameter int DIV_W     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_punch,
  input  logic        btn_kick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef P2_ANIM_MIRROR_EN
  input  logic        facing,
`endif
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_bitmap,
  output logic        sprite_pix,
  output logic [2:0]  action,
  output logic [1:0]  frame,
  output logic        busy,
  output logic        hit
);

  localparam logic [2:0] ACT_STAY  = 3'd0;
  localparam logic [2:0] ACT_FWD   = 3'd1;
  localparam logic [2:0] ACT_BACK  = 3'd2;
  localparam logic [2:0] ACT_PUNCH = 3'd3;
  localparam logic [2:0] ACT_KICK  = 3'd4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [2:0]       action_q, action_d;
  logic [1:0]       frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_p_q, pend_p_d;
  logic             pend_k_q, pend_k_d;
  logic             prev_p_q, prev_k_q;
  logic             hit_q, hit_d;
  logic             take_p, take_k;
  logic             step;
  logic [2:0]       tgt;

  logic [9:0]       dx, dy;
  logic             in_box;
  logic             in_box_q;
  logic [3:0]       col_q;
  logic [3:0]       bit_idx;
  logic             sprite_q;

  // Divider: a step fires on the FRAME_DIV-th frame tick
  assign step  = frame_tick && (div_q == DIV_LAST);
  always_comb begin
    div_d = div_q;
    if (frame_tick) div_d = step ? '0 : div_q + 1'b1;
  end

  // A rising edge seen in the same clk as a consuming step is kept
  always_comb begin
    pend_p_d = (pend_p_q && !take_p) || (btn_punch && !prev_p_q);
    pend_k_d = (pend_k_q && !take_k) || (btn_kick && !prev_k_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      action_q <= ACT_STAY;
      frame_q  <= 2'd0;
    end else begin
      action_q <= action_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    action_d = action_q;
    frame_d  = frame_q;
    take_p   = 1'b0;
    take_k   = 1'b0;
    tgt      = ACT_STAY;
    if (step) begin
      if (busy && frame_q != 2'd3) begin
        frame_d = frame_q + 2'd1;
      end else if (pend_p_q) begin
        action_d = ACT_PUNCH;
        frame_d  = 2'd0;
        take_p   = 1'b1;
        take_k   = 1'b1;
      end else if (pend_k_q) begin
        action_d = ACT_KICK;
        frame_d  = 2'd0;
        take_k   = 1'b1;
      end else begin
        if (btn_right)     tgt = ACT_FWD;
        else if (btn_left) tgt = ACT_BACK;
        if (tgt == action_q) begin
          frame_d = frame_q + 2'd1;
        end else begin
          action_d = tgt;
          frame_d  = 2'd0;
        end
      end
    end
  end

  always_comb begin
    busy  = (action_q == ACT_PUNCH) || (action_q == ACT_KICK);
    hit_d = step && (frame_d == 2'd2) &&
            ((action_d == ACT_PUNCH) || (action_d == ACT_KICK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pend_p_q <= 1'b0;
      pend_k_q <= 1'b0;
      prev_p_q <= 1'b0;
      prev_k_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      pend_p_q <= pend_p_d;
      pend_k_q <= pend_k_d;
      prev_p_q <= btn_punch;
      prev_k_q <= btn_kick;
      hit_q    <= hit_d;
    end
  end

  // Negative offsets wrap to large values and fall outside the box
  assign dx     = pix_x - pos_x;
  assign dy     = pix_y - pos_y;
  assign in_box = (dx[9:4] == 6'd0) && (dy[9:4] == 6'd0);

  always_comb begin
    rom_addr = 10'd0;
    if (in_box) rom_addr = {dy[3:0], action_q, 1'b0, frame_q};
  end

`ifdef P2_ANIM_MIRROR_EN
  logic facing_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) facing_q <= 1'b0;
    else        facing_q <= facing;
  end
  assign bit_idx = facing_q ? col_q : ~col_q;
`else
  assign bit_idx = ~col_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_q <= 1'b0;
      col_q    <= 4'd0;
      sprite_q <= 1'b0;
    end else begin
      in_box_q <= in_box;
      col_q    <= dx[3:0];
      sprite_q <= in_box_q && !rom_bitmap[bit_idx];
    end
  end

  assign sprite_pix = sprite_q;
  assign action     = action_q;
  assign frame      = frame_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_p2_anim_ctrl.sv
// Scoreboard bench for p2_anim_ctrl (FRAME_DIV=2).
// Expectations are queued per cycle and checked at the falling edge.
module tb_p2_anim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        btn_left, btn_right, btn_punch, btn_kick;
  logic [9:0]  pix_x, pix_y, pos_x, pos_y;
  logic [9:0]  rom_addr;
  logic [15:0] rom_bitmap;
  logic        sprite_pix;
  logic [2:0]  action;
  logic [1:0]  frame;
  logic        busy, hit;
`ifdef P2_ANIM_MIRROR_EN
  logic        facing;
`endif

  p2_anim_ctrl #(.FRAME_DIV(2), .DIV_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_punch  (btn_punch),
    .btn_kick   (btn_kick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
`ifdef P2_ANIM_MIRROR_EN
    .facing     (facing),
`endif
    .rom_addr   (rom_addr),
    .rom_bitmap (rom_bitmap),
    .sprite_pix (sprite_pix),
    .action     (action),
    .frame      (frame),
    .busy       (busy),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  typedef enum int {F_ACT, F_FRM, F_BSY, F_HIT, F_PIX, F_ADR} fld_t;
  typedef struct {
    int    cyc;
    string name;
    fld_t  fld;
    int    val;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_val(fld_t f);
    case (f)
      F_ACT:   return int'(action);
      F_FRM:   return int'(frame);
      F_BSY:   return int'(busy);
      F_HIT:   return int'(hit);
      F_PIX:   return int'(sprite_pix);
      default: return int'(rom_addr);
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle
  always @(negedge clk) begin
    item_t it;
    int    got;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      n_vec++;
      if (it.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: check missed at cycle %0d, expected %0d",
                 it.name, cyc, it.val);
      end else begin
        got = get_val(it.fld);
        if (got != it.val) begin
          n_err++;
          $display("FAIL %s: got %0d, expected %0d", it.name, got, it.val);
        end
      end
    end
  end

  task automatic push(string n, fld_t f, int v);
    item_t it;
    it.cyc  = cyc;
    it.name = n;
    it.fld  = f;
    it.val  = v;
    sb.push_back(it);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      clk1();
      frame_tick = 1'b0;
    end
  endtask

  task automatic push_state(string n, int a, int f, int b);
    push({n, "_act"}, F_ACT, a);
    push({n, "_frm"}, F_FRM, f);
    push({n, "_bsy"}, F_BSY, b);
  endtask

  int exp_f [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0;
    btn_punch = 1'b0; btn_kick = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    pos_x = 10'd0; pos_y = 10'd0;
    rom_bitmap = 16'hFFFF;
`ifdef P2_ANIM_MIRROR_EN
    facing = 1'b0;
`endif
    repeat (3) clk1();
    push_state("rst", 0, 0, 0);
    push("rst_hit", F_HIT, 0);
    push("rst_pix", F_PIX, 0);
    clk1();
    rst_n = 1'b1;
    clk1();

    // Pixel pipeline: sprite at (100,50)
    pos_x = 10'd100; pos_y = 10'd50;
    pix_x = 10'd103; pix_y = 10'd52;
    push("addr_a", F_ADR, 10'o0200);
    clk1();
    rom_bitmap = 16'b1111110000111111;
    pix_x = 10'd107;
    clk1();
    push("pix_a_bit12", F_PIX, 0);
    pix_x = 10'd99;
    push("addr_left_out", F_ADR, 0);
    clk1();
    push("pix_b_bit8", F_PIX, 1);
    rom_bitmap = 16'h0000;
    pix_x = 10'd100; pix_y = 10'd66;
    push("addr_below_out", F_ADR, 0);
    clk1();
    push("pix_c_dx_neg", F_PIX, 0);
    pix_x = 10'd115; pix_y = 10'd65;
    push("addr_corner", F_ADR, 10'h3C0);
    clk1();
    push("pix_d_dy16", F_PIX, 0);
    rom_bitmap = 16'hFFFE;
    pix_x = 10'd0; pix_y = 10'd0;
    clk1();
    push("pix_e_col15", F_PIX, 1);
    rom_bitmap = 16'hFFFF;
`ifdef P2_ANIM_MIRROR_EN
    pix_x = 10'd102; pix_y = 10'd52; facing = 1'b1;
    clk1();
    rom_bitmap = 16'h00FF;
    facing = 1'b0;
    clk1();
    push("mirror_col2", F_PIX, 0);
    rom_bitmap = 16'h00FF;
    pix_x = 10'd0; pix_y = 10'd0;
    clk1();
    push("nomirror_col2", F_PIX, 1);
    rom_bitmap = 16'hFFFF;
`endif
    clk1();

    // Stay cycle: one frame step per two ticks
    for (int i = 0; i < 10; i++) begin
      ftick(1);
      push($sformatf("stay_frm%0d", i), F_FRM, exp_f[i]);
    end
    push("stay_act", F_ACT, 0);

    // Punch with forward held
    btn_punch = 1'b1;
    clk1();
    btn_punch = 1'b0;
    btn_right = 1'b1;
    ftick(1);
    push("pun_wait_act", F_ACT, 0);
    ftick(1);
    push_state("pun_f0", 3, 0, 1);
    ftick(2);
    push("pun_f1", F_FRM, 1);
    ftick(2);
    push_state("pun_f2", 3, 2, 1);
    push("pun_hit", F_HIT, 1);
    clk1();
    push("pun_hit_end", F_HIT, 0);
    ftick(2);
    push_state("pun_f3", 3, 3, 1);
    ftick(2);
    push_state("pun_done", 1, 0, 0);

    // Async reset mid-punch at frame 2
    btn_right = 1'b0;
    btn_punch = 1'b1;
    clk1();
    btn_punch = 1'b0;
    ftick(6);
    rst_n = 1'b0;
    push_state("arst", 0, 0, 0);
    push("arst_hit", F_HIT, 0);
    push("arst_pix", F_PIX, 0);
    clk1();
    rst_n = 1'b1;
    clk1();

    // Punch and kick rise together: kick is dropped
    btn_punch = 1'b1; btn_kick = 1'b1;
    clk1();
    btn_punch = 1'b0; btn_kick = 1'b0;
    ftick(2);
    push_state("sim_f0", 3, 0, 1);
    ftick(6);
    push("sim_f3", F_FRM, 3);
    ftick(2);
    push_state("sim_done", 0, 0, 0);
    ftick(2);
    push_state("sim_nokick", 0, 1, 0);

    // Kick requested mid-punch waits for the punch to end
    btn_punch = 1'b1;
    clk1();
    btn_punch = 1'b0;
    ftick(2);
    push_state("q_pun", 3, 0, 1);
    ftick(2);
    btn_kick = 1'b1;
    clk1();
    btn_kick = 1'b0;
    btn_left = 1'b1; btn_right = 1'b1;
    ftick(4);
    push_state("q_locked", 3, 3, 1);
    ftick(2);
    push_state("q_kick", 4, 0, 1);
    ftick(4);
    push("kick_hit", F_HIT, 1);
    push("kick_f2", F_FRM, 2);
    ftick(2);
    push("kick_f3", F_FRM, 3);
    ftick(2);
    push_state("r_over_l", 1, 0, 0);
    ftick(2);
    push_state("fwd_wrap", 1, 1, 0);
    btn_right = 1'b0;
    ftick(2);
    push_state("back", 2, 0, 0);

    repeat (3) clk1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete, %0d pending", sb.size());
    $fatal(1, "timeout");
  end

endmodule
